// File: rtl/jtframe_obj_pkg.sv
// Shared types and constants for the per-line object scheduler.
// Optional vertical flip on palette bit 7 is enabled by JTFRAME_OBJ_VFLIP_EN.
package jtframe_obj_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        RD_X   = 3'd2,
        RD_Y   = 3'd3,
        RD_PAL = 3'd4,
        ISSUE  = 3'd5,
        DONE   = 3'd6
    } obj_st_e;

    localparam logic [7:0] LUT_END = 8'hFF;
    localparam int         OBJ_H   = 16;

    localparam int ID  = 0;
    localparam int X   = 1;
    localparam int Y   = 2;
    localparam int PAL = 3;

endpackage

// File: rtl/jtframe_obj_sched_if.sv
// LUT read port and draw-request handshake between scheduler and drawer.
// Plain bus bundle; the vertical-flip option (JTFRAME_OBJ_VFLIP_EN) does not change it.
interface jtframe_obj_sched_if #(
    parameter int AW = 12
);
    logic [AW-1:0] lut_addr;
    logic [7:0]    lut_data;
    logic          dr_valid;
    logic          dr_ready;
    logic [7:0]    dr_id;
    logic [7:0]    dr_x;
    logic [3:0]    dr_pal;
    logic [3:0]    dr_row;

    modport master (
        output lut_addr,
        input  lut_data,
        output dr_valid,
        input  dr_ready,
        output dr_id,
        output dr_x,
        output dr_pal,
        output dr_row
    );

    modport slave (
        input  lut_addr,
        output lut_data,
        input  dr_valid,
        output dr_ready,
        input  dr_id,
        input  dr_x,
        input  dr_pal,
        input  dr_row
    );
endinterface

// File: rtl/jtframe_obj_vmatch.sv
// Vertical hit test: line offset from object top, visibility and row.
// Flip input is driven from palette bit 7 only with JTFRAME_OBJ_VFLIP_EN.
module jtframe_obj_vmatch
    import jtframe_obj_pkg::*;
#(
    parameter int VW = 11
) (
    input  logic [VW-1:0] vline_i,
    input  logic [7:0]    y_i,
    input  logic          flip_i,
    output logic          visible_o,
    output logic [3:0]    row_o
);
    logic [VW-1:0] base;
    logic [VW-1:0] diff;

    // modulo subtraction lets objects near the bottom wrap to line 0
    assign base      = VW'({y_i, 3'b000});
    assign diff      = vline_i - base;
    assign visible_o = diff < VW'(OBJ_H);
    assign row_o     = flip_i ? ~diff[3:0] : diff[3:0];

endmodule

// File: rtl/jtframe_obj_sched.sv
// Per-line object scheduler: walks the object LUT on hb and feeds the drawer.
// Optional vertical flip on palette bit 7 with JTFRAME_OBJ_VFLIP_EN.
module jtframe_obj_sched
    import jtframe_obj_pkg::*;
#(
    parameter int VW      = 11,
    parameter int AW      = 12,
    parameter int ENTRIES = 256,
    parameter int MAXOBJ  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hb,
    input  logic [VW-1:0]        vline,
    jtframe_obj_sched_if.master  bus,
    output logic                 line,
    output logic                 busy,
    output logic                 ovf,
    output logic                 late
);
    localparam int EW = $clog2(ENTRIES + 1);
    localparam int IW = $clog2(MAXOBJ + 1);

    obj_st_e       st_q, st_d;
    logic          ph_q, ph_d;
    logic          hb_q;
    logic [AW-1:0] addr_q, addr_d;
    logic [VW-1:0] vl_q, vl_d;
    logic [EW-1:0] ent_q, ent_d;
    logic [IW-1:0] iss_q, iss_d;
    logic [7:0]    id_q, id_d;
    logic [7:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;
    logic [3:0]    pal_q, pal_d;
    logic [3:0]    row_q, row_d;
    logic          vld_q, vld_d;
    logic          line_q, line_d;
    logic          ovf_q, ovf_d;
    logic          late_q, late_d;
    logic          hb_rise, last, flip, vis;
    logic [3:0]    row;
    logic [7:0]    ysel;

    assign hb_rise = hb & ~hb_q;
    assign last    = ent_q == EW'(ENTRIES - 1);
    assign busy    = (st_q != IDLE) && (st_q != DONE);
    assign ysel    = (st_q == RD_Y) ? bus.lut_data : y_q;

`ifdef JTFRAME_OBJ_VFLIP_EN
    assign flip = bus.lut_data[7];
`else
    assign flip = 1'b0;
`endif

    jtframe_obj_vmatch #(.VW(VW)) u_vmatch (
        .vline_i   (vl_q),
        .y_i       (ysel),
        .flip_i    (flip),
        .visible_o (vis),
        .row_o     (row)
    );

    always_comb begin
        st_d   = st_q;
        ph_d   = ph_q;
        addr_d = addr_q;
        vl_d   = vl_q;
        ent_d  = ent_q;
        iss_d  = iss_q;
        id_d   = id_q;
        x_d    = x_q;
        y_d    = y_q;
        pal_d  = pal_q;
        row_d  = row_q;
        vld_d  = vld_q;
        line_d = line_q;
        ovf_d  = ovf_q;
        late_d = late_q;
        if (hb_rise) begin
            line_d = ~line_q;
            vl_d   = vline;
            ent_d  = '0;
            iss_d  = '0;
            late_d = busy;
            ovf_d  = 1'b0;
            vld_d  = 1'b0;
            st_d   = RD_ID;
            ph_d   = 1'b0;
            addr_d = '0;
        end else begin
            unique case (st_q)
                RD_ID, RD_X, RD_Y, RD_PAL: ph_d = ~ph_q;
                default: ;
            endcase
            unique case (st_q)
                RD_ID: if (ph_q) begin
                    id_d   = bus.lut_data;
                    addr_d = addr_q + 1'b1;
                    st_d   = (bus.lut_data == LUT_END) ? DONE : RD_X;
                end
                RD_X: if (ph_q) begin
                    x_d    = bus.lut_data;
                    addr_d = addr_q + 1'b1;
                    st_d   = RD_Y;
                end
                RD_Y: if (ph_q) begin
                    y_d = bus.lut_data;
                    if (vis) begin
                        addr_d = addr_q + 1'b1;
                        st_d   = RD_PAL;
                    end else begin
                        // address stays put once the entry budget is spent
                        addr_d = last ? addr_q : addr_q + AW'(PAL - Y + 1);
                        ent_d  = ent_q + 1'b1;
                        st_d   = last ? DONE : RD_ID;
                    end
                end
                RD_PAL: if (ph_q) begin
                    if (iss_q == IW'(MAXOBJ)) begin
                        addr_d = addr_q + 1'b1;
                        ovf_d  = 1'b1;
                        st_d   = DONE;
                    end else begin
                        addr_d = last ? addr_q : addr_q + 1'b1;
                        pal_d  = bus.lut_data[3:0];
                        row_d  = row;
                        vld_d  = 1'b1;
                        st_d   = ISSUE;
                    end
                end
                // the wait here doubles as address setup for the next id byte
                ISSUE: if (bus.dr_ready) begin
                    vld_d = 1'b0;
                    iss_d = iss_q + 1'b1;
                    ent_d = ent_q + 1'b1;
                    st_d  = last ? DONE : RD_ID;
                    ph_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            ph_q   <= 1'b0;
            hb_q   <= 1'b0;
            addr_q <= '0;
            vl_q   <= '0;
            ent_q  <= '0;
            iss_q  <= '0;
            id_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            pal_q  <= '0;
            row_q  <= '0;
            vld_q  <= 1'b0;
            line_q <= 1'b0;
            ovf_q  <= 1'b0;
            late_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            ph_q   <= ph_d;
            hb_q   <= hb;
            addr_q <= addr_d;
            vl_q   <= vl_d;
            ent_q  <= ent_d;
            iss_q  <= iss_d;
            id_q   <= id_d;
            x_q    <= x_d;
            y_q    <= y_d;
            pal_q  <= pal_d;
            row_q  <= row_d;
            vld_q  <= vld_d;
            line_q <= line_d;
            ovf_q  <= ovf_d;
            late_q <= late_d;
        end
    end

    assign bus.lut_addr = addr_q;
    assign bus.dr_valid = vld_q;
    assign bus.dr_id    = id_q;
    assign bus.dr_x     = x_q;
    assign bus.dr_pal   = pal_q;
    assign bus.dr_row   = row_q;
    assign line         = line_q;
    assign ovf          = ovf_q;
    assign late         = late_q;

endmodule
